load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath width; legal values 32 or 64.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 15, maximum wait cycles for data_valid before a bus error.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port valid  input  1  instruction in stage is valid.
REQ-006 SHALL have ports load / store  input  1 each  access type from decode.
REQ-007 SHALL have port fun3  input  3  instruction[14:12], access size and signedness.
REQ-008 SHALL have port alu_out_address  input  DATA_WIDTH  effective byte address.
REQ-009 SHALL have port operand_b  input  DATA_WIDTH  store source data, LSB-aligned.
REQ-010 SHALL have ports data_valid  input  1  memory acknowledge; wrap_load_in  input  DATA_WIDTH  raw read word.
REQ-011 SHALL have ports request  output  1  bus request; we_re  output  1  1=write, 0=read.
REQ-012 SHALL have ports mask  output  DATA_WIDTH/8  byte enables; mem_address  output  DATA_WIDTH  word-aligned address.
REQ-013 SHALL have ports store_data_out  output  DATA_WIDTH  lane-shifted store data; wrap_load_out  output  DATA_WIDTH  extended load result.
REQ-014 SHALL have ports done, stall, bus_error, misaligned  output  1 each.

Function
REQ-015 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE.
REQ-016 IDLE: valid & (load XOR store) SHALL capture address, fun3, operand_b and type, then move to ACCESS next cycle.
REQ-017 IDLE with load & store both high, or valid low, SHALL start no access; stall SHALL be 0.
REQ-018 ACCESS SHALL hold request=1, we_re=store, mask, mem_address and store_data_out stable from registered values until exit.
REQ-019 ACCESS with data_valid=1 SHALL move to DONE; for loads, wrap_load_out SHALL be registered on that edge.
REQ-020 DONE SHALL pulse done=1 for exactly one cycle; request SHALL be 0; next state is IDLE.
REQ-021 Minimum latency: acceptance cycle + 1 ACCESS cycle + DONE = done three cycles after acceptance when data_valid is immediate.
REQ-022 stall SHALL equal (IDLE & valid & (load XOR store)) | ACCESS; stall SHALL be 0 in DONE.
REQ-023 A wait counter SHALL count ACCESS cycles without data_valid; at TIMEOUT_CYCLES it SHALL drop request, go to DONE and pulse bus_error with done.
REQ-024 data_valid arriving in the same cycle the counter reaches TIMEOUT_CYCLES SHALL complete normally, with no bus_error.
REQ-025 Sizes SHALL be: fun3 000 byte, 001 half, 010 word, 011 dword (64 only); loads 100 LBU, 101 LHU, 110 LWU (64 only) zero-extend; other load codes sign-extend.
REQ-026 An unsupported fun3 for DATA_WIDTH SHALL issue no request and SHALL go directly to DONE with bus_error=1.
REQ-027 mask SHALL set size-many contiguous bits starting at address[log2(DATA_WIDTH/8)-1:0]; store_data_out SHALL be operand_b shifted left by 8*byte offset.
REQ-028 Load extraction SHALL shift wrap_load_in right by 8*byte offset, then extend to DATA_WIDTH.
REQ-029 mem_address SHALL be the captured address with low log2(DATA_WIDTH/8) bits zeroed.
REQ-030 data_valid outside ACCESS SHALL be ignored.

Reset
REQ-031 rst=0 SHALL asynchronously force IDLE, counter 0, and request, we_re, mask, mem_address, store_data_out, wrap_load_out, done, stall, bus_error and misaligned to 0.
REQ-032 Reset during ACCESS SHALL drop request immediately, with no done pulse.

Configuration
REQ-033 With MISALIGN_TRAP_EN defined, an access not naturally aligned to its size SHALL issue no request and SHALL go to DONE with misaligned=1.
REQ-034 Without MISALIGN_TRAP_EN, misaligned SHALL be tied 0, and offset bits below the access size SHALL be forced to 0 before masking and shifting.

Verification
REQ-035 LW to 0x100, data_valid in the first ACCESS cycle, wrap_load_in=0xDEADBEEF -> request for 1 cycle, mask 0xF, wrap_load_out 0xDEADBEEF, done 3 cycles after acceptance.
REQ-036 LB to 0x103, wrap_load_in=0x80FFFFFF -> mask 0x8, wrap_load_out 0xFFFFFF80; LBU same -> 0x00000080.
REQ-037 SH to 0x102, operand_b=0x0000ABCD -> we_re 1, mask 0xC, store_data_out 0xABCD0000, mem_address 0x100.
REQ-038 LW, data_valid never asserted, TIMEOUT_CYCLES=15 -> request high for 15 cycles, then bus_error and done pulse together, stall released.
REQ-039 LW to 0x101 -> with MISALIGN_TRAP_EN: no request, misaligned=1 with done; without it: mask 0xF, mem_address 0x100.
REQ-040 rst low on the 3rd wait cycle of a store -> request 0 in the same cycle, FSM IDLE, no done pulse after release.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding access, byte-lane steering, load extension, bus timeout.
// Define MISALIGN_TRAP_EN to trap accesses not naturally aligned to their size.
module load_store_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid,
  input  logic                    load,
  input  logic                    store,
  input  logic [2:0]              fun3,
  input  logic [DATA_WIDTH-1:0]   alu_out_address,
  input  logic [DATA_WIDTH-1:0]   operand_b,
  input  logic                    data_valid,
  input  logic [DATA_WIDTH-1:0]   wrap_load_in,
  output logic                    request,
  output logic                    we_re,
  output logic [DATA_WIDTH/8-1:0] mask,
  output logic [DATA_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]   store_data_out,
  output logic [DATA_WIDTH-1:0]   wrap_load_out,
  output logic                    done,
  output logic                    stall,
  output logic                    bus_error,
  output logic                    misaligned
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] opb_q;
  logic [2:0]            fun3_q;
  logic                  store_q;
  logic                  bus_err_q;
  logic [CNT_W-1:0]      wait_cnt;

  logic                  start;
  logic                  in_supported;
  logic                  timeout;
  logic                  set_err;
  logic [OFF_W-1:0]      off_eff;
  logic [NB-1:0]         mask_c;
  logic [DATA_WIDTH-1:0] load_shifted;
  logic [DATA_WIDTH-1:0] load_ext;

  // Store codes with fun3[2] set do not exist; dword and LWU need the 64-bit datapath.
  function automatic logic fun3_supported(input logic [2:0] f, input logic st);
    logic ok;
    ok = 1'b1;
    if (st) begin
      ok = !f[2] && ((f[1:0] != 2'b11) || (DATA_WIDTH == 64));
    end else begin
      case (f)
        3'b011, 3'b110: ok = (DATA_WIDTH == 64);
        3'b111:         ok = 1'b0;
        default:        ok = 1'b1;
      endcase
    end
    return ok;
  endfunction

  function automatic logic [OFF_W-1:0] size_lsbs(input logic [1:0] sz);
    return OFF_W'((32'd1 << sz) - 32'd1);
  endfunction

  assign start        = (state == IDLE) && valid && (load ^ store);
  assign in_supported = fun3_supported(fun3, store);
  assign timeout      = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef MISALIGN_TRAP_EN
  logic in_misaligned;
  logic set_mis;
  logic mis_q;

  assign in_misaligned = (alu_out_address[OFF_W-1:0] & size_lsbs(fun3[1:0])) != '0;
  assign set_mis       = start && in_supported && in_misaligned;
  assign misaligned    = done & mis_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mis_q <= 1'b0;
    end else if (start) begin
      mis_q <= set_mis;
    end
  end
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    set_err    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stall = 1'b1;
          if (!in_supported) begin
            set_err    = 1'b1;
            state_next = DONE;
          end
`ifdef MISALIGN_TRAP_EN
          else if (in_misaligned) begin
            state_next = DONE;
          end
`endif
          else begin
            state_next = ACCESS;
          end
        end
      end
      ACCESS: begin
        stall = 1'b1;
        // A late acknowledge on the final wait cycle still wins over the timeout.
        if (data_valid) begin
          state_next = DONE;
        end else if (timeout) begin
          set_err    = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      addr_q        <= '0;
      opb_q         <= '0;
      fun3_q        <= '0;
      store_q       <= 1'b0;
      bus_err_q     <= 1'b0;
      wait_cnt      <= '0;
      wrap_load_out <= '0;
    end else begin
      state <= state_next;
      if (start) begin
        addr_q    <= alu_out_address;
        opb_q     <= operand_b;
        fun3_q    <= fun3;
        store_q   <= store;
        bus_err_q <= set_err;
      end else if (state == ACCESS) begin
        bus_err_q <= set_err;
      end
      wait_cnt <= ((state == ACCESS) && !data_valid) ? wait_cnt + 1'b1 : '0;
      if ((state == ACCESS) && data_valid && !store_q) begin
        wrap_load_out <= load_ext;
      end
    end
  end

  // Offset bits below the access size are dropped so lanes always stay naturally aligned.
  assign off_eff = addr_q[OFF_W-1:0] & ~size_lsbs(fun3_q[1:0]);

  always_comb begin
    mask_c = '0;
    for (int i = 0; i < NB; i++) begin
      if ((i >= int'(off_eff)) && (i < int'(off_eff) + (1 << fun3_q[1:0]))) begin
        mask_c[i] = 1'b1;
      end
    end
  end

  assign load_shifted = wrap_load_in >> {off_eff, 3'b000};

  always_comb begin
    load_ext = load_shifted;
    case (fun3_q[1:0])
      2'b00:   load_ext = fun3_q[2] ? DATA_WIDTH'(load_shifted[7:0])
                                    : DATA_WIDTH'($signed(load_shifted[7:0]));
      2'b01:   load_ext = fun3_q[2] ? DATA_WIDTH'(load_shifted[15:0])
                                    : DATA_WIDTH'($signed(load_shifted[15:0]));
      2'b10:   load_ext = fun3_q[2] ? DATA_WIDTH'(load_shifted[31:0])
                                    : DATA_WIDTH'($signed(load_shifted[31:0]));
      default: load_ext = load_shifted;
    endcase
  end

  assign request        = (state == ACCESS);
  assign we_re          = request & store_q;
  assign mask           = request ? mask_c : '0;
  assign mem_address    = request ? {addr_q[DATA_WIDTH-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign store_data_out = request ? (opb_q << {off_eff, 3'b000}) : '0;
  assign done           = (state == DONE);
  assign bus_error      = done & bus_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit (32-bit) against a byte-arithmetic reference model.
module tb_load_store_unit;

  localparam int DW = 32;
  localparam int TO = 15;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid, load, store, data_valid;
  logic [2:0]    fun3;
  logic [DW-1:0] alu_out_address, operand_b, wrap_load_in;
  logic          request, we_re, done, stall, bus_error, misaligned;
  logic [DW/8-1:0] mask;
  logic [DW-1:0] mem_address, store_data_out, wrap_load_out;

  int total  = 0;
  int passed = 0;
  logic [31:0] last_load = '0;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .valid(valid), .load(load), .store(store), .fun3(fun3),
    .alu_out_address(alu_out_address), .operand_b(operand_b), .data_valid(data_valid),
    .wrap_load_in(wrap_load_in), .request(request), .we_re(we_re), .mask(mask),
    .mem_address(mem_address), .store_data_out(store_data_out),
    .wrap_load_out(wrap_load_out), .done(done), .stall(stall),
    .bus_error(bus_error), .misaligned(misaligned)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // One complete access; delay = ACCESS cycles before data_valid (>= TO means never).
  task automatic applyStimulus(input bit st, input logic [2:0] f, input logic [31:0] addr,
                               input logic [31:0] opb, input logic [31:0] rdata,
                               input int delay);
    int size, off, cycles, exp_req;
    bit err, mis, exp_err;
    logic [63:0] v, lim, exp_mask, exp_store;
    size = 1 << f[1:0];
    off  = addr % 4;
    err  = st ? (f > 3'd2) : (f == 3'd3 || f == 3'd6 || f == 3'd7);
    mis  = !err && TRAP && (off % size != 0);
    if (!TRAP) off = off - (off % size);
    exp_mask  = ((64'd1 << size) - 64'd1) << off;
    exp_store = (64'(opb) << (8 * off)) & 64'hFFFF_FFFF;
    v   = 64'(rdata) >> (8 * off);
    lim = 64'd1 << (8 * size);
    if (size < 4) begin
      v = v & (lim - 64'd1);
      if (!f[2] && ((v >> (8 * size - 1)) & 64'd1) != 0) v = (v - lim) & 64'hFFFF_FFFF;
    end

    @(negedge clk);
    valid = 1'b1; load = !st; store = st; fun3 = f;
    alu_out_address = addr; operand_b = opb; wrap_load_in = rdata;
    data_valid = 1'($urandom_range(0, 1));
    #1;
    checkOutput("stall_accept", stall, 1);
    checkOutput("req_in_idle", request, 0);
    @(negedge clk);
    valid = 1'b0; data_valid = 1'b0;

    if (err || mis) begin
      checkOutput("trap_request", request, 0);
      checkOutput("trap_done", done, 1);
      checkOutput("trap_bus_error", bus_error, err);
      checkOutput("trap_misaligned", misaligned, mis);
      checkOutput("trap_stall", stall, 0);
      @(negedge clk);
      checkOutput("trap_done_clear", done, 0);
      return;
    end

    cycles = 0;
    while (cycles < 40 && request === 1'b1) begin
      checkOutput("we_re", we_re, st);
      checkOutput("mask", mask, exp_mask);
      checkOutput("mem_address", mem_address, addr & 32'hFFFF_FFFC);
      checkOutput("store_data", store_data_out, exp_store);
      checkOutput("stall_access", stall, 1);
      checkOutput("done_in_access", done, 0);
      data_valid = (cycles == delay);
      cycles++;
      @(negedge clk);
      data_valid = 1'b0;
    end
    exp_req = (delay < TO) ? delay + 1 : TO;
    exp_err = (delay >= TO);
    checkOutput("request_cycles", cycles, exp_req);
    checkOutput("done_pulse", done, 1);
    checkOutput("done_request", request, 0);
    checkOutput("done_stall", stall, 0);
    checkOutput("done_bus_error", bus_error, exp_err);
    checkOutput("done_misaligned", misaligned, 0);
    if (!st && !exp_err) last_load = v[31:0];
    checkOutput("load_data", wrap_load_out, last_load);
    @(negedge clk);
    checkOutput("done_clear", done, 0);
  endtask

  // Idle noise: invalid or double-typed instructions and stray acknowledges.
  task automatic idleNoise(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid = 1'($urandom_range(0, 1));
      if (valid) begin load = 1'b1; store = 1'b1; end
      else begin load = 1'($urandom_range(0, 1)); store = 1'($urandom_range(0, 1)); end
      data_valid = 1'b1;
      #1;
      checkOutput("idle_stall", stall, 0);
      @(negedge clk);
      checkOutput("idle_request", request, 0);
      checkOutput("idle_done", done, 0);
      valid = 1'b0; data_valid = 1'b0;
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    valid = 0; load = 0; store = 0; fun3 = 0; data_valid = 0;
    alu_out_address = 0; operand_b = 0; wrap_load_in = 0;
    repeat (2) @(negedge clk);
    checkOutput("rst_request", request, 0);
    checkOutput("rst_mask", mask, 0);
    checkOutput("rst_mem_address", mem_address, 0);
    checkOutput("rst_load_out", wrap_load_out, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_stall", stall, 0);
    rst = 1'b1;

    applyStimulus(0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    applyStimulus(0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 0);
    applyStimulus(0, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 1);
    applyStimulus(1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 0);
    applyStimulus(0, 3'b010, 32'h200, 32'h0, 32'h12345678, TO + 5);
    applyStimulus(0, 3'b010, 32'h204, 32'h0, 32'hCAFEF00D, TO - 1);
    applyStimulus(0, 3'b010, 32'h101, 32'h0, 32'h11223344, 0);
    applyStimulus(0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
    applyStimulus(0, 3'b110, 32'h100, 32'h0, 32'h0, 0);
    applyStimulus(1, 3'b011, 32'h100, 32'h5, 32'h0, 0);
    idleNoise(4);

    // Reset on the third wait cycle of a store.
    @(negedge clk);
    valid = 1; store = 1; load = 0; fun3 = 3'b010; alu_out_address = 32'h300;
    @(negedge clk);
    valid = 0; store = 0;
    repeat (2) @(negedge clk);
    checkOutput("pre_reset_request", request, 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("reset_request", request, 0);
    checkOutput("reset_stall", stall, 0);
    checkOutput("reset_we_re", we_re, 0);
    checkOutput("reset_load_out", wrap_load_out, 0);
    last_load = '0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("post_reset_done", done, 0);
      checkOutput("post_reset_request", request, 0);
    end

    for (int n = 0; n < 80; n++) begin
      bit st;
      logic [2:0] f;
      int r, delay;
      st = 1'($urandom_range(0, 1));
      f  = st ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      r  = $urandom_range(0, 9);
      delay = (r < 7) ? (r % 4) : ((r == 7) ? TO - 1 : ((r == 8) ? TO : TO + 3));
      applyStimulus(st, f, $urandom, $urandom, $urandom, delay);
      if (n % 10 == 0) idleNoise(2);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
